// File: rtl/pooling_stream_pkg.sv
// Shared types and width helper for the streaming K x K pooling engine.
package pool_pkg;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pool_state_e;

    // Wide enough to hold K*K full-scale elements without overflow.
    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned k);
        return data_width + 2 * $clog2(k);
    endfunction

endpackage

// File: rtl/pooling_stream_if.sv
// Pixel-in / pooled-pixel-out valid/ready bus for pooling_stream.
interface pooling_stream_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 4
);
    logic                           in_valid;
    logic                           in_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] in_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pooling_stream_lane.sv
// One channel lane: folds a pixel into its window accumulator and finalises it.
module pool_lane
    import pool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned K          = 2,
    localparam int unsigned ACC_W     = acc_width(DATA_WIDTH, K),
    localparam int unsigned SH        = 2 * $clog2(K)
) (
    input  logic                  first,
    input  pool_mode_e            mode,
    input  logic [ACC_W-1:0]      acc,
    input  logic [DATA_WIDTH-1:0] pixel,
    output logic [ACC_W-1:0]      acc_next,
    output logic [DATA_WIDTH-1:0] result
);
    logic [ACC_W-1:0] pix_ext;

    always_comb begin
        pix_ext = ACC_W'(pixel);
        if (first) begin
            acc_next = pix_ext;
        end else if (mode == POOL_MAX) begin
            acc_next = (pix_ext > acc) ? pix_ext : acc;
        end else begin
            acc_next = acc + pix_ext;
        end
    end

    // Max never exceeds DATA_WIDTH bits; the average is the sum's top DATA_WIDTH bits.
    always_comb begin
        if (mode == POOL_MAX) begin
            result = acc_next[DATA_WIDTH-1:0];
        end else begin
            result = acc_next[SH +: DATA_WIDTH];
        end
    end

endmodule

// File: rtl/pooling_stream.sv
// Streaming K x K / stride-K max or average pooling over a raster-ordered feature map.
module pooling_stream
    import pool_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned K          = 2,
    parameter int unsigned IMG_W      = 8,
    parameter int unsigned IMG_H      = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            mode,
    pooling_stream_if.slave strm,
    output logic            busy,
    output logic            frame_done
);
    localparam int unsigned ACC_W = acc_width(DATA_WIDTH, K);
    localparam int unsigned LOG_K = $clog2(K);
    localparam int unsigned NCOL  = IMG_W / K;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned IDX_W = (NCOL > 1) ? $clog2(NCOL) : 1;

    pool_state_e state, state_d;
    pool_mode_e  mode_q;
    logic        done_d;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [IDX_W-1:0] idx;

    logic [ACC_W-1:0] acc      [NCOL][CHANNELS];
    logic [ACC_W-1:0] acc_next [CHANNELS];
    logic [CHANNELS*DATA_WIDTH-1:0] result;

    logic                           out_valid_q;
    logic [CHANNELS*DATA_WIDTH-1:0] out_data_q;

    logic accept, first_px, win_done, col_end, row_end;

    assign strm.in_ready  = (state == RUN) && (!out_valid_q || strm.out_ready);
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign busy           = (state != IDLE);

    assign accept   = strm.in_valid && strm.in_ready;
    assign idx      = IDX_W'(col >> LOG_K);
    assign first_px = (row[LOG_K-1:0] == '0) && (col[LOG_K-1:0] == '0);
    assign win_done = (row[LOG_K-1:0] == '1) && (col[LOG_K-1:0] == '1);
    assign col_end  = (col == COL_W'(IMG_W - 1));
    assign row_end  = (row == ROW_W'(IMG_H - 1));

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        pool_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .K          (K)
        ) u_lane (
            .first    (first_px),
            .mode     (mode_q),
            .acc      (acc[idx][c]),
            .pixel    (strm.in_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .acc_next (acc_next[c]),
            .result   (result[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // DRAIN leaves on the edge where the final output is consumed, so frame_done
    // and the fall of busy appear together in the following cycle.
    always_comb begin
        state_d = state;
        done_d  = 1'b0;
        unique case (state)
            IDLE:  if (start) state_d = RUN;
            RUN:   if (accept && col_end && row_end) state_d = DRAIN;
            DRAIN: if (!out_valid_q || strm.out_ready) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            frame_done  <= 1'b0;
            mode_q      <= POOL_AVG;
            col         <= '0;
            row         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state      <= state_d;
            frame_done <= done_d;
            if (state == IDLE && start) begin
                mode_q <= pool_mode_e'(mode);
                col    <= '0;
                row    <= '0;
            end
            if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            if (accept && win_done) begin
                out_valid_q <= 1'b1;
                out_data_q  <= result;
            end else if (strm.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Each window's first pixel overwrites its entry, so the buffer needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                acc[idx][c] <= acc_next[c];
            end
        end
    end

endmodule
